point_loader: RTL

- Producer side of the sort block's load interface.
- Collects one object point and six hexagon vertices from a serial coordinate stream and registers them as packed {X,Y} words G1..G6.
- Fires a single-cycle finish_load, then holds all point registers stable until the sorter returns finish_sort.
- Reports completion to downstream logic (geofence test/area stage), which then reads the sorted vertices.

---
 rtl/point_loader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/point_loader.sv
// point_loader: producer side of the sort block's load interface.
// Collects one object point and six hexagon vertices from a serial {X,Y}
// coordinate stream, raises a single-cycle finish_load and then freezes
// the point registers until the sorter answers with finish_sort.
// Optional feature macro: LOADER_TIMEOUT_EN (abandon the wait after
// SORT_TIMEOUT cycles without finish_sort and pulse sort_timeout).
module point_loader #(
    parameter int COORD_W      = 10,
    parameter int SORT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [COORD_W-1:0]     in_X,
    input  logic [COORD_W-1:0]     in_Y,
    output logic                   in_ready,
    input  logic                   finish_sort,
    output logic [2*COORD_W-1:0]   obj,
    output logic [2*COORD_W-1:0]   G1,
    output logic [2*COORD_W-1:0]   G2,
    output logic [2*COORD_W-1:0]   G3,
    output logic [2*COORD_W-1:0]   G4,
    output logic [2*COORD_W-1:0]   G5,
    output logic [2*COORD_W-1:0]   G6,
    output logic                   finish_load,
    output logic                   busy,
    output logic                   set_valid,
    output logic                   sort_timeout
);

    localparam int PW = 2 * COORD_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIRE = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;
    logic            r_in_ready;
    logic            r_finish_load;
    logic            r_busy;
    logic            r_set_valid;
    logic            w_set_valid_nxt;
    logic [PW-1:0]   r_obj;
    logic [PW-1:0]   r_g [0:5];
    logic            w_accept;
    logic            w_timeout;
    logic [PW-1:0]   w_point;

    // A pair is taken only while the registered ready is high; nothing is buffered.
    assign w_accept = in_valid && r_in_ready;
    assign w_point  = {in_X, in_Y};

`ifdef LOADER_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_sort_timeout;

    // finish_sort arriving on the last wait cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !finish_sort &&
                       (r_wait_cnt == 8'(SORT_TIMEOUT - 1));

    // Wait timer: held at zero outside S_WAIT, counts each cycle spent waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    // Registered one-cycle timeout pulse, aligned with the return to S_IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sort_timeout <= 1'b0;
        end else begin
            r_sort_timeout <= w_timeout;
        end
    end

    assign sort_timeout = r_sort_timeout;
`else
    // Without the timer the loader waits for finish_sort indefinitely.
    assign w_timeout    = 1'b0 & (SORT_TIMEOUT != 0);
    assign sort_timeout = 1'b0;
`endif

    // Next-state, load counter and set_valid decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_set_valid_nxt = r_set_valid;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_LOAD;
                    w_cnt_nxt       = 3'd1;
                    w_set_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (r_cnt >= 3'd6) begin
                        // Sixth vertex stored: counter saturates, never wraps past G6.
                        w_state_nxt = S_FIRE;
                        w_cnt_nxt   = 3'd6;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = r_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_FIRE: begin
                // finish_sort seen here is deliberately ignored.
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (finish_sort) begin
                    w_state_nxt     = S_IDLE;
                    w_cnt_nxt       = 3'd0;
                    w_set_valid_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_cnt_nxt       = 3'd0;
                    w_set_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_cnt_nxt       = 3'd0;
                w_set_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 3'd0;
            r_in_ready    <= 1'b1;
            r_finish_load <= 1'b0;
            r_busy        <= 1'b0;
            r_set_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_in_ready    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_finish_load <= (w_state_nxt == S_FIRE);
            r_busy        <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_FIRE) ||
                             (w_state_nxt == S_WAIT);
            r_set_valid   <= w_set_valid_nxt;
        end
    end

    // Point capture: registers change only on an accepted pair, so the
    // sorter sees G1..G6 frozen from finish_load until the next set starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_obj <= {PW{1'b0}};
            for (int i = 0; i < 6; i++) begin
                r_g[i] <= {PW{1'b0}};
            end
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_obj <= w_point;
            end else if (r_state == S_LOAD) begin
                case (r_cnt)
                    3'd1:    r_g[0] <= w_point;
                    3'd2:    r_g[1] <= w_point;
                    3'd3:    r_g[2] <= w_point;
                    3'd4:    r_g[3] <= w_point;
                    3'd5:    r_g[4] <= w_point;
                    3'd6:    r_g[5] <= w_point;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign finish_load = r_finish_load;
    assign busy        = r_busy;
    assign set_valid   = r_set_valid;
    assign obj         = r_obj;
    assign G1          = r_g[0];
    assign G2          = r_g[1];
    assign G3          = r_g[2];
    assign G4          = r_g[3];
    assign G5          = r_g[4];
    assign G6          = r_g[5];

endmodule
